// File: rtl/branch_predictor_if.sv
// Fetch/execute-side signals of the bimodal branch predictor.
// The master drives the PCs and the resolved outcomes; the slave is the predictor.
interface branch_predictor_if;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        upd_pred;
    logic        flush;
    logic        mispredict;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    modport master (
        output pred_valid, pred_pc, upd_valid, upd_pc, upd_taken, upd_pred, flush,
        input  pred_taken, mispredict, stat_branches, stat_mispredicts
    );

    modport slave (
        input  pred_valid, pred_pc, upd_valid, upd_pc, upd_taken, upd_pred, flush,
        output pred_taken, mispredict, stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/branch_predictor.sv
// Bimodal predictor: a table of 2-bit saturating counters indexed by PC[INDEX_BITS+1:2].
// Define BHT_STATS_EN to add saturating resolved-branch and misprediction counters.
module branch_predictor #(
    parameter int INDEX_BITS = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    branch_predictor_if.slave  bp
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam logic [1:0] CTR_INIT = 2'b01;

    logic [1:0]            r_ctr [ENTRIES];
    logic [INDEX_BITS-1:0] w_pred_idx;
    logic [INDEX_BITS-1:0] w_upd_idx;
    logic                  w_accept;
    logic                  w_unused_pc_bits;

    function automatic logic [1:0] f_ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken)
            return (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        else
            return (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
    endfunction

    assign w_pred_idx = bp.pred_pc[INDEX_BITS+1:2];
    assign w_upd_idx  = bp.upd_pc[INDEX_BITS+1:2];
    assign w_accept   = bp.upd_valid & ~bp.flush;

    assign w_unused_pc_bits = ^{bp.pred_pc[31:INDEX_BITS+2], bp.pred_pc[1:0],
                                bp.upd_pc[31:INDEX_BITS+2], bp.upd_pc[1:0]};

    // Reads see the pre-update table; a same-cycle update lands at the edge.
    assign bp.pred_taken = bp.pred_valid & r_ctr[w_pred_idx][1];
    assign bp.mispredict = bp.upd_valid & (bp.upd_taken != bp.upd_pred);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= CTR_INIT;
        end else if (bp.flush) begin
            for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= CTR_INIT;
        end else if (bp.upd_valid) begin
            r_ctr[w_upd_idx] <= f_ctr_next(r_ctr[w_upd_idx], bp.upd_taken);
        end
    end

`ifdef BHT_STATS_EN
    logic [31:0] r_stat_branches;
    logic [31:0] r_stat_mispredicts;

    function automatic logic [31:0] f_sat_inc(input logic [31:0] val);
        return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
    endfunction

    // Flush discards the update, so it is not counted either; stats survive flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_branches    <= 32'h0;
            r_stat_mispredicts <= 32'h0;
        end else if (w_accept) begin
            r_stat_branches <= f_sat_inc(r_stat_branches);
            if (bp.mispredict)
                r_stat_mispredicts <= f_sat_inc(r_stat_mispredicts);
        end
    end

    assign bp.stat_branches    = r_stat_branches;
    assign bp.stat_mispredicts = r_stat_mispredicts;
`else
    logic w_unused_accept;
    assign w_unused_accept     = w_accept;
    assign bp.stat_branches    = 32'h0;
    assign bp.stat_mispredicts = 32'h0;
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// Directed and random checks of branch_predictor against an array-of-integers model.
module tb_branch_predictor;
    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    int          m_ctr [64];
    longint      m_branches;
    longint      m_mispredicts;

    branch_predictor_if bp_if ();

    branch_predictor #(.INDEX_BITS(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bp_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    task automatic model_reset_table();
        for (int i = 0; i < 64; i++) m_ctr[i] = 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_stat(input longint v);
`ifdef BHT_STATS_EN
        return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
`else
        return (v < 0) ? 32'h1 : 32'h0;
`endif
    endfunction

    // One clock cycle: drive, check the combinational outputs, clock, advance the model.
    task automatic step(input string tag, input logic pv, input logic [31:0] ppc,
                        input logic uv, input logic [31:0] upc, input logic ut,
                        input logic up, input logic fl);
        logic exp_pred;
        logic exp_mis;
        bp_if.pred_valid = pv;
        bp_if.pred_pc    = ppc;
        bp_if.upd_valid  = uv;
        bp_if.upd_pc     = upc;
        bp_if.upd_taken  = ut;
        bp_if.upd_pred   = up;
        bp_if.flush      = fl;
        #2;
        exp_pred = pv && (m_ctr[idx_of(ppc)] >= 2);
        exp_mis  = uv && (ut != up);
        chk({tag, ".pred"}, {31'h0, bp_if.pred_taken}, {31'h0, exp_pred});
        chk({tag, ".mis"}, {31'h0, bp_if.mispredict}, {31'h0, exp_mis});
        chk({tag, ".sbr"}, bp_if.stat_branches, exp_stat(m_branches));
        chk({tag, ".smp"}, bp_if.stat_mispredicts, exp_stat(m_mispredicts));
        @(posedge clk);
        if (fl) begin
            model_reset_table();
        end else if (uv) begin
            int k;
            k = idx_of(upc);
            if (ut) m_ctr[k] = (m_ctr[k] == 3) ? 3 : m_ctr[k] + 1;
            else    m_ctr[k] = (m_ctr[k] == 0) ? 0 : m_ctr[k] - 1;
            m_branches++;
            if (ut != up) m_mispredicts++;
        end
        #1;
    endtask

    task automatic upd(input string tag, input logic [31:0] pc, input logic t, input logic p);
        step(tag, 1'b1, pc, 1'b1, pc, t, p, 1'b0);
    endtask

    task automatic predict(input string tag, input logic [31:0] pc);
        step(tag, 1'b1, pc, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_flush(input string tag);
        step(tag, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        compared      = 0;
        mismatched    = 0;
        m_branches    = 0;
        m_mispredicts = 0;
        model_reset_table();
        rst_n = 1'b0;
        bp_if.pred_valid = 1'b1;
        bp_if.pred_pc    = 32'h100;
        bp_if.upd_valid  = 1'b0;
        bp_if.upd_pc     = 32'h0;
        bp_if.upd_taken  = 1'b0;
        bp_if.upd_pred   = 1'b0;
        bp_if.flush      = 1'b0;
        #3;
        chk("rst.pred", {31'h0, bp_if.pred_taken}, 32'h0);
        chk("rst.mis", {31'h0, bp_if.mispredict}, 32'h0);
        chk("rst.sbr", bp_if.stat_branches, 32'h0);
        chk("rst.smp", bp_if.stat_mispredicts, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic training of 0x100: 01 -> 10.
        predict("p100", 32'h100);
        upd("u100", 32'h100, 1'b1, 1'b0);
        predict("p100b", 32'h100);
        chk("p100b.const", {31'h0, bp_if.pred_taken}, 32'h1);
        step("pv0", 1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Saturate high then walk down at 0x204 (index 1).
        do_flush("fl1");
        upd("t1", 32'h204, 1'b1, 1'b0);
        upd("t2", 32'h204, 1'b1, 1'b1);
        upd("t3", 32'h204, 1'b1, 1'b1);
        upd("n1", 32'h204, 1'b0, 1'b1);
        predict("p204a", 32'h204);
        upd("n2", 32'h204, 1'b0, 1'b1);
        predict("p204b", 32'h204);
        upd("n3", 32'h204, 1'b0, 1'b0);
        upd("n4", 32'h204, 1'b0, 1'b0);
        predict("p204c", 32'h204);

        // Aliasing: 0x100 and 0x200 share index 0; 0x104 is index 1.
        do_flush("fl2");
        upd("a1", 32'h100, 1'b1, 1'b0);
        upd("a2", 32'h100, 1'b1, 1'b1);
        predict("alias200", 32'h200);
        chk("alias200.const", {31'h0, bp_if.pred_taken}, 32'h1);
        predict("alias103", 32'h103);
        predict("idx104", 32'h104);

        // Same-cycle read and update of one entry sees the old value.
        do_flush("fl3");
        upd("same", 32'h100, 1'b1, 1'b0);
        predict("same.next", 32'h100);

        // Flush wins over a simultaneous update.
        upd("pre", 32'h300, 1'b1, 1'b0);
        step("flupd", 1'b1, 32'h300, 1'b1, 32'h300, 1'b1, 1'b0, 1'b1);
        predict("postfl", 32'h300);
        chk("postfl.const", {31'h0, bp_if.pred_taken}, 32'h0);

        // Randomized traffic with frequent aliasing and occasional flushes.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ppc, upc;
            logic        uv, ut, up, fl;
            upc = $urandom_range(0, 31) * 32'd4 + ($urandom_range(0, 3) << 8) + $urandom_range(0, 3);
            ppc = ($urandom_range(0, 3) == 0) ? upc : $urandom();
            uv  = $urandom_range(0, 3) != 0;
            ut  = $urandom_range(0, 1) == 1;
            up  = ($urandom_range(0, 3) == 0) ? ~ut : (m_ctr[idx_of(upc)] >= 2);
            fl  = $urandom_range(0, 49) == 0;
            step("rnd", $urandom_range(0, 7) != 0, ppc, uv, upc, ut, up, fl);
        end

        // Asynchronous reset mid-cycle with an update pending.
        upd("pre2", 32'h100, 1'b1, 1'b1);
        upd("pre3", 32'h100, 1'b1, 1'b1);
        bp_if.pred_valid = 1'b1;
        bp_if.pred_pc    = 32'h100;
        bp_if.upd_valid  = 1'b1;
        bp_if.upd_pc     = 32'h100;
        bp_if.upd_taken  = 1'b1;
        bp_if.upd_pred   = 1'b0;
        bp_if.flush      = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset_table();
        m_branches    = 0;
        m_mispredicts = 0;
        chk("arst.pred", {31'h0, bp_if.pred_taken}, 32'h0);
        chk("arst.sbr", bp_if.stat_branches, 32'h0);
        chk("arst.smp", bp_if.stat_mispredicts, 32'h0);
        @(posedge clk);
        #1;
        bp_if.upd_valid = 1'b0;
        rst_n = 1'b1;
        predict("arst.after", 32'h100);
        upd("arst.upd", 32'h100, 1'b1, 1'b0);
        predict("arst.trained", 32'h100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
